cursor_step_ctrl: RTL and testbench

CURSOR_STEP_CTRL -- requirements
Module: cursor_step_ctrl

---
 rtl/cursor_pkg.sv | 55 +++++
 rtl/cursor_step_timer.sv | 36 +++
 rtl/cursor_step_ctrl.sv | 144 ++++++++++++++
 tb/tb_cursor_step_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// Shared types, button bit positions, screen bounds and coordinate step helpers for the cursor controller.
// Step helpers saturate at the bounds by default; define CURSOR_WRAP_EN to make them wrap instead.
package cursor_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned BTN_W   = 4;

  localparam int unsigned BTN_XINC = 0;
  localparam int unsigned BTN_YDEC = 1;
  localparam int unsigned BTN_YINC = 2;
  localparam int unsigned BTN_XDEC = 3;

  localparam int unsigned DEF_X     = 320;
  localparam int unsigned DEF_Y     = 240;
  localparam int unsigned DEF_MAX_X = 639;
  localparam int unsigned DEF_MAX_Y = 479;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REPEAT   = 2'd3
  } state_t;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic coord_t coord_inc(input coord_t v, input coord_t lim);
`ifdef CURSOR_WRAP_EN
    return (v >= lim) ? '0 : v + coord_t'(1);
`else
    return (v >= lim) ? lim : v + coord_t'(1);
`endif
  endfunction

  function automatic coord_t coord_dec(input coord_t v, input coord_t lim);
`ifdef CURSOR_WRAP_EN
    return (v == '0) ? lim : v - coord_t'(1);
`else
    return (v == '0) ? '0 : v - coord_t'(1);
`endif
  endfunction

endpackage

// File: rtl/cursor_step_timer.sv
// Reloadable down-counter; expired is a registered flag that is high while the count sits at zero.
module cursor_step_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;
  logic         expired_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      expired_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      expired_q <= (count_d == '0);
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/cursor_step_ctrl.sv
// Button-driven cursor with debounce and auto-repeat, plus an absolute host load path.
// Bound behaviour (saturate or wrap) follows CURSOR_WRAP_EN via the cursor_pkg step helpers.
module cursor_step_ctrl
  import cursor_pkg::*;
#(
  parameter int unsigned DEFAULT_X     = DEF_X,
  parameter int unsigned DEFAULT_Y     = DEF_Y,
  parameter int unsigned MAX_X         = DEF_MAX_X,
  parameter int unsigned MAX_Y         = DEF_MAX_Y,
  parameter int unsigned DEBOUNCE_CYC  = 50000,
  parameter int unsigned REPEAT_DELAY  = 5000000,
  parameter int unsigned REPEAT_PERIOD = 500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BTN_W-1:0]   btn,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [COORD_W-1:0] host_x,
  input  logic [COORD_W-1:0] host_y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               step
);

  localparam int unsigned MAX_CNT = max3(DEBOUNCE_CYC - 1, REPEAT_DELAY - 1, REPEAT_PERIOD - 1);
  localparam int unsigned TIMER_W = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);

  localparam coord_t LIM_X = coord_t'(MAX_X);
  localparam coord_t LIM_Y = coord_t'(MAX_Y);

  logic [BTN_W-1:0]   sync1_q, sbtn_q;
  state_t             state_q, state_d;
  logic [BTN_W-1:0]   dir_q, dir_d;
  logic               pend_q, pend_d;
  logic               step_q;
  logic               host_ready_q;
  pos_t               pos_q, pos_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_expired;
  logic               host_accept;

  cursor_step_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Debounce/repeat sequencing; any change of the synchronized buttons aborts to IDLE.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pend_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if ($onehot(sbtn_q)) begin
          state_d  = ST_DEBOUNCE;
          dir_d    = sbtn_q;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(DEBOUNCE_CYC - 1);
        end
      end
      ST_DEBOUNCE: begin
        if (sbtn_q != dir_q) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          state_d  = ST_HOLD;
          pend_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(REPEAT_DELAY - 1);
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (sbtn_q != dir_q) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          state_d  = ST_REPEAT;
          pend_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(REPEAT_PERIOD - 1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pending button step owns the position register; host loads wait for it to drain.
  assign host_accept = host_valid && host_ready_q;

  always_comb begin
    pos_d = pos_q;
    if (pend_q) begin
      if (dir_q[BTN_XINC]) begin
        pos_d.x = coord_inc(pos_q.x, LIM_X);
      end else if (dir_q[BTN_XDEC]) begin
        pos_d.x = coord_dec(pos_q.x, LIM_X);
      end else if (dir_q[BTN_YINC]) begin
        pos_d.y = coord_inc(pos_q.y, LIM_Y);
      end else if (dir_q[BTN_YDEC]) begin
        pos_d.y = coord_dec(pos_q.y, LIM_Y);
      end
    end else if (host_accept) begin
      pos_d.x = (host_x > LIM_X) ? LIM_X : host_x;
      pos_d.y = (host_y > LIM_Y) ? LIM_Y : host_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sbtn_q       <= '0;
      state_q      <= ST_IDLE;
      dir_q        <= '0;
      pend_q       <= 1'b0;
      step_q       <= 1'b0;
      host_ready_q <= 1'b1;
      pos_q.x      <= coord_t'(DEFAULT_X);
      pos_q.y      <= coord_t'(DEFAULT_Y);
    end else begin
      sync1_q      <= btn;
      sbtn_q       <= sync1_q;
      state_q      <= state_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      step_q       <= pend_q;
      host_ready_q <= !pend_d;
      pos_q        <= pos_d;
    end
  end

  assign host_ready = host_ready_q;
  assign x          = pos_q.x;
  assign y          = pos_q.y;
  assign step       = step_q;

endmodule

// File: tb/tb_cursor_step_ctrl.sv
// Directed bench for cursor_step_ctrl with short debounce/repeat timings and hand-computed expectations.
module tb_cursor_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       host_valid;
  logic       host_ready;
  logic [9:0] host_x, host_y;
  logic [9:0] x, y;
  logic       step;

  int checks   = 0;
  int failures = 0;

  cursor_step_ctrl #(
    .DEFAULT_X     (320),
    .DEFAULT_Y     (240),
    .MAX_X         (639),
    .MAX_Y         (479),
    .DEBOUNCE_CYC  (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_x     (host_x),
    .host_y     (host_y),
    .x          (x),
    .y          (y),
    .step       (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    btn        = 4'b0000;
    host_valid = 1'b0;
    host_x     = '0;
    host_y     = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
  endtask

  int exp_x;
  int exp_s;
  int wrap_x;

  initial begin
    // Reset state
    rst = 1'b0; btn = '0; host_valid = 1'b0; host_x = '0; host_y = '0;
    tick();
    chk("rst_x", 32'(x), 320);
    chk("rst_y", 32'(y), 240);
    chk("rst_step", 32'(step), 0);
    chk("rst_ready", 32'(host_ready), 1);
    rst = 1'b1;
    tick();

    // Held x+1: steps at edges 7, 17, 20, 23, 26
    do_reset();
    btn = 4'b0001;
    for (int e = 0; e <= 26; e++) begin
      tick();
      exp_x = (e >= 26) ? 325 : (e >= 23) ? 324 : (e >= 20) ? 323 :
              (e >= 17) ? 322 : (e >= 7) ? 321 : 320;
      exp_s = (e == 7 || e == 17 || e == 20 || e == 23 || e == 26) ? 1 : 0;
      chk($sformatf("hold_x_e%0d", e), 32'(x), 32'(exp_x));
      chk($sformatf("hold_step_e%0d", e), 32'(step), 32'(exp_s));
    end
    // Release: one more step already in the synchronizer pipeline lands at edge 29
    btn = 4'b0000;
    for (int e = 27; e <= 34; e++) tick();
    chk("hold_release_x", 32'(x), 326);
    chk("hold_release_y", 32'(y), 240);

    // Short press: no step
    do_reset();
    btn = 4'b0001;
    tick(); tick(); tick();
    btn = 4'b0000;
    for (int e = 0; e < 15; e++) begin
      tick();
      chk($sformatf("short_step_%0d", e), 32'(step), 0);
    end
    chk("short_x", 32'(x), 320);

    // Multi-hot buttons ignored
    do_reset();
    btn = 4'b1010;
    for (int e = 0; e < 30; e++) begin
      tick();
      chk($sformatf("multi_step_%0d", e), 32'(step), 0);
    end
    chk("multi_x", 32'(x), 320);
    chk("multi_y", 32'(y), 240);

    // Host load to origin, then x-1 at the lower bound
    do_reset();
`ifdef CURSOR_WRAP_EN
    wrap_x = 639;
`else
    wrap_x = 0;
`endif
    host_valid = 1'b1; host_x = 10'd0; host_y = 10'd0;
    tick();
    host_valid = 1'b0;
    chk("load0_x", 32'(x), 0);
    chk("load0_y", 32'(y), 0);
    btn = 4'b1000;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e == 6) chk("bound_x_before", 32'(x), 0);
    end
    chk("bound_step", 32'(step), 1);
    chk("bound_x", 32'(x), 32'(wrap_x));
    btn = 4'b0000;
    for (int e = 0; e < 12; e++) tick();
    chk("bound_x_settled", 32'(x), 32'(wrap_x));
    chk("bound_y_settled", 32'(y), 0);

    // Host load colliding with a pending step, with x clamping
    do_reset();
    btn = 4'b0001;
    for (int e = 0; e <= 5; e++) tick();
    chk("arb_ready_e5", 32'(host_ready), 1);
    tick();
    chk("arb_ready_e6", 32'(host_ready), 0);
    host_valid = 1'b1; host_x = 10'd700; host_y = 10'd5;
    tick();
    chk("arb_x_e7", 32'(x), 321);
    chk("arb_step_e7", 32'(step), 1);
    chk("arb_ready_e7", 32'(host_ready), 1);
    tick();
    host_valid = 1'b0;
    chk("arb_x_e8", 32'(x), 639);
    chk("arb_y_e8", 32'(y), 5);
    btn = 4'b0000;
    for (int e = 0; e < 12; e++) tick();
    chk("arb_x_settled", 32'(x), 639);

    // Reset while auto-repeating, button kept held
    do_reset();
    btn = 4'b0001;
    for (int e = 0; e <= 20; e++) tick();
    chk("mid_x_before", 32'(x), 323);
    rst = 1'b0;
    #1;
    chk("mid_rst_x", 32'(x), 320);
    chk("mid_rst_y", 32'(y), 240);
    chk("mid_rst_step", 32'(step), 0);
    chk("mid_rst_ready", 32'(host_ready), 1);
    tick();
    tick();
    rst = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      chk($sformatf("mid_step_r%0d", e), 32'(step), (e == 7) ? 1 : 0);
    end
    chk("mid_x_after", 32'(x), 321);
    btn = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
